// File: rtl/mac_pkg.sv
// Shared types and constants for the RMII Ethernet transmit engine.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    HDR,
    PAY,
    PAD,
    FCS,
    IFG
  } mac_state_e;

  localparam logic [47:0] DST_MAC  = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] SRC_MAC  = 48'h00_0A_35_00_01_02;
  localparam logic [15:0] ETH_TYPE = 16'h88B5;

  localparam logic [10:0] MAX_PAYLOAD = 11'd1500;
  localparam logic [10:0] MIN_PAYLOAD = 11'd46;

  localparam logic [3:0] PRE_BYTES = 4'd7;
  localparam logic [3:0] HDR_BYTES = 4'd14;
  localparam logic [3:0] FCS_BYTES = 4'd4;
  localparam logic [3:0] IFG_BYTES = 4'd12;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  // Header byte idx (0..13): DA, SA, EtherType, each MSB byte first.
  function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
    logic [111:0] hdr;
    hdr = {DST_MAC, SRC_MAC, ETH_TYPE} << {idx, 3'b000};
    return hdr[111:104];
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 next-state over one byte, reflected (LSB-first) form.
module crc32_d8
  import mac_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      crc_out = (crc_out[0] ^ data[i]) ? ((crc_out >> 1) ^ CRC_POLY_REFL) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/mac_tx.sv
// RMII transmit engine: preamble, SFD, fixed header, payload, padding and FCS,
// serialised as 2-bit dibits LSB-first, four clocks per byte.
module mac_tx
  import mac_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       busy,
  output logic [1:0] txd,
  output logic       tx_en
);

  mac_state_e  state;
  logic [3:0]  byte_cnt;
  logic [1:0]  dibit_cnt;
  logic [5:0]  shifter;
  logic [10:0] pay_cnt;
  logic        pay_done;
  logic [31:0] crc_reg;
  logic [31:0] crc_next;
  logic [7:0]  next_byte;
  logic        byte_end;
  logic        pay_slot;

  assign byte_end = (dibit_cnt == 2'd3);

  // Byte boundary at which an upstream byte must be taken (or the frame aborted).
  assign pay_slot = ((state == HDR) && (byte_cnt == HDR_BYTES - 4'd1)) ||
                    ((state == PAY) && !pay_done);

  always_comb begin
    next_byte = 8'h00;
    case (state)
      PRE: next_byte = (byte_cnt == PRE_BYTES - 4'd1) ? SFD_BYTE : PREAMBLE_BYTE;
      SFD: next_byte = hdr_byte(4'd0);
      HDR: next_byte = (byte_cnt == HDR_BYTES - 4'd1) ? s_data : hdr_byte(byte_cnt + 4'd1);
      PAY: begin
        if (!pay_done)                  next_byte = s_data;
        else if (pay_cnt < MIN_PAYLOAD) next_byte = 8'h00;
        else                            next_byte = ~crc_reg[7:0];
      end
      PAD: next_byte = (pay_cnt == MIN_PAYLOAD) ? ~crc_reg[7:0] : 8'h00;
      FCS: begin
        case (byte_cnt[1:0])
          2'd0:    next_byte = ~crc_reg[15:8];
          2'd1:    next_byte = ~crc_reg[23:16];
          default: next_byte = ~crc_reg[31:24];
        endcase
      end
      default: next_byte = 8'h00;
    endcase
  end

  crc32_d8 u_crc (
    .crc_in  (crc_reg),
    .data    (next_byte),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      dibit_cnt <= '0;
      shifter   <= '0;
      pay_cnt   <= '0;
      pay_done  <= 1'b0;
      crc_reg   <= CRC_INIT;
      txd       <= 2'b00;
      tx_en     <= 1'b0;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      s_ready <= 1'b0;
      if (state == IDLE) begin
        if (s_valid) begin
          state     <= PRE;
          byte_cnt  <= '0;
          dibit_cnt <= '0;
          txd       <= PREAMBLE_BYTE[1:0];
          shifter   <= PREAMBLE_BYTE[7:2];
          tx_en     <= 1'b1;
          busy      <= 1'b1;
          crc_reg   <= CRC_INIT;
          pay_cnt   <= '0;
          pay_done  <= 1'b0;
        end
      end else if (state == IFG) begin
        dibit_cnt <= dibit_cnt + 2'd1;
        if (byte_end) begin
          if (byte_cnt == IFG_BYTES - 4'd1) begin
            state    <= IDLE;
            busy     <= 1'b0;
            byte_cnt <= '0;
          end else begin
            byte_cnt <= byte_cnt + 4'd1;
          end
        end
      end else begin
        dibit_cnt <= dibit_cnt + 2'd1;
        if (!byte_end) begin
          txd     <= shifter[1:0];
          shifter <= {2'b00, shifter[5:2]};
          s_ready <= (dibit_cnt == 2'd2) && pay_slot;
        end else begin
          txd     <= next_byte[1:0];
          shifter <= next_byte[7:2];
          if (pay_slot) begin
            if (s_valid) begin
              state    <= PAY;
              crc_reg  <= crc_next;
              pay_cnt  <= pay_cnt + 11'd1;
              pay_done <= s_last || (pay_cnt == MAX_PAYLOAD - 11'd1);
            end else begin
              // Underrun: drop the frame without FCS and go straight to the gap.
              state    <= IFG;
              tx_en    <= 1'b0;
              txd      <= 2'b00;
              byte_cnt <= '0;
            end
          end else begin
            case (state)
              PRE: begin
                byte_cnt <= byte_cnt + 4'd1;
                if (byte_cnt == PRE_BYTES - 4'd1) state <= SFD;
              end
              SFD: begin
                state    <= HDR;
                byte_cnt <= '0;
                crc_reg  <= crc_next;
              end
              HDR: begin
                byte_cnt <= byte_cnt + 4'd1;
                crc_reg  <= crc_next;
              end
              PAY, PAD: begin
                if (pay_cnt < MIN_PAYLOAD) begin
                  state   <= PAD;
                  crc_reg <= crc_next;
                  pay_cnt <= pay_cnt + 11'd1;
                end else begin
                  state    <= FCS;
                  byte_cnt <= '0;
                end
              end
              FCS: begin
                if (byte_cnt == FCS_BYTES - 4'd1) begin
                  state    <= IFG;
                  tx_en    <= 1'b0;
                  txd      <= 2'b00;
                  byte_cnt <= '0;
                end else begin
                  byte_cnt <= byte_cnt + 4'd1;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_tx.sv
// Directed bench for mac_tx: decodes the RMII stream and checks frames against expected bytes.
module tb_mac_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic       busy;
  logic [1:0] txd;
  logic       tx_en;

  int n_checks;
  int n_fail;

  mac_tx dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .busy    (busy),
    .txd     (txd),
    .tx_en   (tx_en)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  logic [7:0] hdr_tbl [0:13] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                 8'h00, 8'h0A, 8'h35, 8'h00, 8'h01, 8'h02,
                                 8'h88, 8'hB5};

  // Upstream source: {last, data} entries, presented on the falling edge.
  logic [8:0] src[$];
  bit         pend;

  initial begin
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    pend    = 1'b0;
    forever begin
      @(negedge clk);
      if (pend && src.size() > 0) void'(src.pop_front());
      if (src.size() > 0) begin
        s_valid = 1'b1;
        s_data  = src[0][7:0];
        s_last  = src[0][8];
      end else begin
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
      end
      pend = s_ready && s_valid;
    end
  end

  // Line monitor: decodes each tx_en burst into bytes.
  logic [7:0] cur_q[$];
  logic [7:0] rx_frame[$];
  logic [7:0] acc;
  int         dib;
  int         run_cycles;
  int         rx_cycles;
  int         frames_done;
  int         idle_run;
  int         last_idle_run;
  int         tail_cnt;
  int         last_tail;
  int         idle_txd_bad;

  initial begin
    acc = 8'h00; dib = 0; run_cycles = 0; rx_cycles = 0; frames_done = 0;
    idle_run = 0; last_idle_run = 0; tail_cnt = 0; last_tail = 0; idle_txd_bad = 0;
    forever begin
      @(negedge clk);
      if (tx_en === 1'b1) begin
        if (run_cycles == 0) last_idle_run = idle_run;
        acc = {txd, acc[7:2]};
        dib++;
        if (dib == 4) begin
          cur_q.push_back(acc);
          dib = 0;
        end
        run_cycles++;
        tail_cnt = 0;
      end else begin
        if (txd !== 2'b00) idle_txd_bad++;
        if (run_cycles > 0) begin
          rx_frame  = cur_q;
          rx_cycles = run_cycles;
          frames_done++;
          cur_q.delete();
          run_cycles = 0;
          dib        = 0;
          idle_run   = 0;
        end
        idle_run++;
        if (busy === 1'b1) tail_cnt++;
        else begin
          if (tail_cnt != 0) last_tail = tail_cnt;
          tail_cnt = 0;
        end
      end
    end
  end

  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build_expected(input bit complete);
    logic [31:0] c;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 14; i++) exp_q.push_back(hdr_tbl[i]);
    foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
    if (complete) begin
      while (exp_q.size() < 68) exp_q.push_back(8'h00);
      c = 32'hFFFFFFFF;
      for (int i = 8; i < exp_q.size(); i++) c = crc_step(c, exp_q[i]);
      c = ~c;
      for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (rx_frame.size() < exp_q.size()) ? rx_frame.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (rx_frame[i] !== exp_q[i]) return i;
    if (rx_frame.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [31:0] rx_residue();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 8; i < rx_frame.size(); i++) c = crc_step(c, rx_frame[i]);
    return c;
  endfunction

  function automatic logic [7:0] rx_at(input int i);
    if (i >= 0 && i < rx_frame.size()) return rx_frame[i];
    return 8'hxx;
  endfunction

  function automatic logic [7:0] exp_at(input int i);
    if (i >= 0 && i < exp_q.size()) return exp_q[i];
    return 8'hxx;
  endfunction

  task automatic wait_frame(input int prev, input int limit, output bit ok);
    for (int i = 0; i < limit; i++) begin
      if (frames_done > prev) break;
      @(posedge clk);
    end
    ok = (frames_done > prev);
  endtask

  task automatic wait_idle(output bit ok);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    ok = (busy === 1'b0);
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (tx_en !== 1'b0) begin n_fail++; $display("FAIL reset_tx_en got %b want 0", tx_en); end
    n_checks++;
    if (txd !== 2'b00) begin n_fail++; $display("FAIL reset_txd got %b want 00", txd); end
    n_checks++;
    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    $display("test_reset: done");
  endtask

  task automatic test_min_frame();
    int prev, n, d, nz;
    bit ok;
    logic [31:0] res;
    pay_q.delete();
    pay_q.push_back(8'hA5);
    prev = frames_done;
    src.push_back({1'b1, 8'hA5});
    n = 0;
    while (s_valid !== 1'b1 && n < 1000) begin #1; n++; end
    n_checks++;
    if (tx_en !== 1'b0) begin n_fail++; $display("FAIL min_pre_start_tx_en got %b want 0", tx_en); end
    @(posedge clk); #1;
    n_checks++;
    if (tx_en !== 1'b1 || txd !== 2'b01 || busy !== 1'b1)
      begin n_fail++; $display("FAIL min_start_latency got tx_en=%b txd=%b busy=%b want 1 01 1", tx_en, txd, busy); end
    wait_frame(prev, 2000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL min_frame_timeout got frames=%0d want >%0d", frames_done, prev); end
    n_checks++;
    if (rx_cycles != 288) begin n_fail++; $display("FAIL min_tx_en_cycles got %0d want 288", rx_cycles); end
    build_expected(1'b1);
    d = first_diff();
    n_checks++;
    if (d >= 0) begin n_fail++; $display("FAIL min_frame_bytes idx %0d got %h want %h", d, rx_at(d), exp_at(d)); end
    nz = 0;
    for (int i = 23; i < 68; i++) if (rx_at(i) !== 8'h00) nz++;
    n_checks++;
    if (rx_at(22) !== 8'hA5 || nz != 0)
      begin n_fail++; $display("FAIL min_pad got payload=%h nonzero_pad=%0d want a5 0", rx_at(22), nz); end
    res = rx_residue();
    n_checks++;
    if (res !== 32'hDEBB20E3) begin n_fail++; $display("FAIL min_residue got %h want debb20e3", res); end
    wait_idle(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL min_idle_timeout got busy=%b want 0", busy); end
    n_checks++;
    if (last_tail != 48) begin n_fail++; $display("FAIL min_ifg_busy got %0d want 48", last_tail); end
    $display("test_min_frame: frame of %0d bytes, %0d cycles", rx_frame.size(), rx_cycles);
  endtask

  task automatic test_46_frame();
    int prev, d;
    bit ok;
    logic [31:0] res;
    pay_q.delete();
    prev = frames_done;
    for (int i = 0; i < 46; i++) begin
      pay_q.push_back(8'(i));
      src.push_back({(i == 45), 8'(i)});
    end
    wait_frame(prev, 2000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL f46_timeout got frames=%0d want >%0d", frames_done, prev); end
    n_checks++;
    if (rx_cycles != 288) begin n_fail++; $display("FAIL f46_tx_en_cycles got %0d want 288", rx_cycles); end
    build_expected(1'b1);
    d = first_diff();
    n_checks++;
    if (d >= 0) begin n_fail++; $display("FAIL f46_frame_bytes idx %0d got %h want %h", d, rx_at(d), exp_at(d)); end
    n_checks++;
    if (rx_at(67) !== 8'h2D) begin n_fail++; $display("FAIL f46_last_payload got %h want 2d", rx_at(67)); end
    res = rx_residue();
    n_checks++;
    if (res !== 32'hDEBB20E3) begin n_fail++; $display("FAIL f46_residue got %h want debb20e3", res); end
    wait_idle(ok);
    $display("test_46_frame: frame of %0d bytes, %0d cycles", rx_frame.size(), rx_cycles);
  endtask

  task automatic test_back_to_back();
    int prev, d;
    bit ok;
    prev = frames_done;
    for (int i = 0; i < 200; i++) src.push_back({(i == 99 || i == 199), 8'(i) ^ 8'h5A});
    pay_q.delete();
    for (int i = 0; i < 100; i++) pay_q.push_back(8'(i) ^ 8'h5A);
    wait_frame(prev, 3000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_first_timeout got frames=%0d want >%0d", frames_done, prev); end
    build_expected(1'b1);
    d = first_diff();
    n_checks++;
    if (d >= 0 || rx_cycles != 504)
      begin n_fail++; $display("FAIL b2b_first_frame idx %0d got %h want %h cycles %0d want 504", d, rx_at(d), exp_at(d), rx_cycles); end
    pay_q.delete();
    for (int i = 100; i < 200; i++) pay_q.push_back(8'(i) ^ 8'h5A);
    wait_frame(prev + 1, 3000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_second_timeout got frames=%0d want >%0d", frames_done, prev + 1); end
    n_checks++;
    if (last_idle_run != 49) begin n_fail++; $display("FAIL b2b_gap got %0d idle cycles want 49", last_idle_run); end
    build_expected(1'b1);
    d = first_diff();
    n_checks++;
    if (d >= 0 || rx_cycles != 504)
      begin n_fail++; $display("FAIL b2b_second_frame idx %0d got %h want %h cycles %0d want 504", d, rx_at(d), exp_at(d), rx_cycles); end
    wait_idle(ok);
    $display("test_back_to_back: second frame %0d bytes, gap %0d", rx_frame.size(), last_idle_run);
  endtask

  task automatic test_truncate();
    int prev, d;
    bit ok;
    prev = frames_done;
    pay_q.delete();
    for (int i = 0; i < 1600; i++) begin
      src.push_back({1'b0, 8'(i * 7 + 3)});
      if (i < 1500) pay_q.push_back(8'(i * 7 + 3));
    end
    wait_frame(prev, 8000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL trunc_first_timeout got frames=%0d want >%0d", frames_done, prev); end
    build_expected(1'b1);
    d = first_diff();
    n_checks++;
    if (d >= 0 || rx_cycles != 6104)
      begin n_fail++; $display("FAIL trunc_first_frame idx %0d got %h want %h cycles %0d want 6104", d, rx_at(d), exp_at(d), rx_cycles); end
    wait_frame(prev + 1, 1000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL trunc_second_timeout got frames=%0d want >%0d", frames_done, prev + 1); end
    n_checks++;
    if (rx_at(22) !== 8'h07 || last_idle_run != 49)
      begin n_fail++; $display("FAIL trunc_next_start got %h gap %0d want 07 gap 49", rx_at(22), last_idle_run); end
    n_checks++;
    if (rx_cycles != 488) begin n_fail++; $display("FAIL trunc_second_len got %0d want 488", rx_cycles); end
    wait_idle(ok);
    $display("test_truncate: second frame starts with %h", rx_at(22));
  endtask

  task automatic test_underrun();
    int prev, d;
    bit ok;
    prev = frames_done;
    pay_q.delete();
    for (int i = 0; i < 9; i++) begin
      pay_q.push_back(8'hC0 + 8'(i));
      src.push_back({1'b0, 8'hC0 + 8'(i)});
    end
    wait_frame(prev, 2000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL underrun_timeout got frames=%0d want >%0d", frames_done, prev); end
    n_checks++;
    if (rx_cycles != 124) begin n_fail++; $display("FAIL underrun_tx_en_cycles got %0d want 124", rx_cycles); end
    build_expected(1'b0);
    d = first_diff();
    n_checks++;
    if (d >= 0) begin n_fail++; $display("FAIL underrun_bytes idx %0d got %h want %h", d, rx_at(d), exp_at(d)); end
    wait_idle(ok);
    n_checks++;
    if (!ok || last_tail != 48) begin n_fail++; $display("FAIL underrun_ifg_busy got %0d want 48", last_tail); end
    $display("test_underrun: aborted frame %0d bytes, busy tail %0d", rx_frame.size(), last_tail);
  endtask

  task automatic test_reset_mid();
    int prev, n, d;
    bit ok;
    for (int i = 0; i < 30; i++) src.push_back({(i == 29), 8'(i)});
    n = 0;
    while (tx_en !== 1'b1 && n < 100) begin @(posedge clk); n++; end
    repeat (40) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_en !== 1'b0 || txd !== 2'b00 || s_ready !== 1'b0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL midreset_outputs got tx_en=%b txd=%b s_ready=%b busy=%b want 0 00 0 0", tx_en, txd, s_ready, busy); end
    src.delete();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || tx_en !== 1'b0) begin n_fail++; $display("FAIL midreset_no_ifg got busy=%b tx_en=%b want 0 0", busy, tx_en); end
    prev = frames_done;
    pay_q.delete();
    pay_q.push_back(8'h11); pay_q.push_back(8'h22); pay_q.push_back(8'h33);
    src.push_back({1'b0, 8'h11}); src.push_back({1'b0, 8'h22}); src.push_back({1'b1, 8'h33});
    wait_frame(prev, 2000, ok);
    build_expected(1'b1);
    d = first_diff();
    n_checks++;
    if (!ok || d >= 0 || rx_cycles != 288)
      begin n_fail++; $display("FAIL midreset_next_frame idx %0d got %h want %h cycles %0d want 288", d, rx_at(d), exp_at(d), rx_cycles); end
    wait_idle(ok);
    n_checks++;
    if (idle_txd_bad != 0) begin n_fail++; $display("FAIL idle_txd got %0d nonzero samples want 0", idle_txd_bad); end
    $display("test_reset_mid: post-reset frame %0d bytes", rx_frame.size());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    test_reset();
    test_min_frame();
    test_46_frame();
    test_back_to_back();
    test_truncate();
    test_underrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
